// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider.
// Produces a registered divided clock whose ratio can be reprogrammed over a
// valid/ready handshake. Ratio changes and stop requests only take effect at
// period boundaries, so out_clk never shows a runt high or low phase.
module clk_div_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         pending,
    output logic [W-1:0] div_active,
    output logic         out_clk,
    output logic         tick
);

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] shadow;

    logic         xfer;
    logic         legal;
    logic         boundary;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] high_len;

    // A shadow ratio blocks further transfers until it has been applied.
    assign cfg_ready = ~pending;

    // Handshake decode, period boundary detect and high-phase length.
    always_comb begin
        xfer     = cfg_valid && cfg_ready;
        legal    = (cfg_div >= W'(2));
        boundary = (state != IDLE) && (cnt == div_active - W'(1));
        cnt_inc  = cnt + W'(1);
        high_len = div_active - (div_active >> 1);
    end

    // Divider state machine, ratio shadowing and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            div_active <= DEF_DIV;
            out_clk    <= 1'b0;
            tick       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= xfer && !legal;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Nothing is running, so a legal ratio applies directly.
                    if (xfer && legal) begin
                        div_active <= cfg_div;
                    end
                    if (en) begin
                        state   <= RUN;
                        out_clk <= 1'b1;
                        tick    <= 1'b1;
                    end else begin
                        out_clk <= 1'b0;
                        tick    <= 1'b0;
                    end
                end
                RUN, STOP: begin
                    if (boundary) begin
                        cnt <= '0;
                        if (pending) begin
                            div_active <= shadow;
                            pending    <= 1'b0;
                        end
                        if (en) begin
                            state   <= RUN;
                            out_clk <= 1'b1;
                            tick    <= 1'b1;
                            // Ratio offered on the boundary waits out the
                            // period that starts now.
                            if (xfer && legal) begin
                                shadow  <= cfg_div;
                                pending <= 1'b1;
                            end
                        end else begin
                            state   <= IDLE;
                            out_clk <= 1'b0;
                            tick    <= 1'b0;
                            // Going idle, so no period can be disturbed.
                            if (xfer && legal) begin
                                div_active <= cfg_div;
                            end
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        out_clk <= (cnt_inc < high_len);
                        tick    <= 1'b0;
                        state   <= en ? RUN : STOP;
                        if (xfer && legal) begin
                            shadow  <= cfg_div;
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    out_clk <= 1'b0;
                    tick    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock divider controller. It generates a registered divided clock `out_clk` from `clk` and accepts new divide ratios over a valid/ready config handshake. Ratio changes and enable/disable take effect only at period boundaries, so no runt or truncated pulse ever appears on `out_clk`. The block sits between the configuration/register interface and clock consumers that need a safely reprogrammable divided clock.

Parameters:
- W, 8, bit width of divide ratio, period counter and config bus.
- DEFAULT_DIV, 4, divide ratio loaded at reset. Must be >= 2 and <= 2^W-1.

Ports:
- clk  input  1  system clock; all logic on posedge only.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  run request for divided clock.
- cfg_valid  input  1  new divide ratio offered.
- cfg_div  input  W  requested divide ratio N.
- cfg_ready  output  1  controller can accept a ratio.
- cfg_err  output  1  one-cycle pulse: last accepted ratio was illegal (<2).
- pending  output  1  valid ratio held in shadow, waiting for period boundary.
- div_active  output  W  ratio currently in effect.
- out_clk  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the first high cycle of every period.

Behaviour:
- Reset (rst_n=0 sampled on posedge) forces the following, with all outputs registered:
  - state=IDLE, out_clk=0, tick=0, cnt=0;
  - div_active=DEFAULT_DIV, shadow discarded, pending=0;
  - cfg_ready=1, cfg_err=0.
  Reset mid-operation aborts the current period immediately.
- Period shape for ratio N:
  - H = N - floor(N/2) high cycles, then L = floor(N/2) low cycles.
  - Examples: N=4 gives 2H/2L; N=5 gives 3H/2L.
  - Counter cnt runs 0..N-1, W bits wide, and wraps to 0 after N-1.
  - out_clk=1 exactly when cnt<H while in RUN.
- States:
  - IDLE: out_clk=0, cnt held at 0. If en=1 is sampled at edge k, then RUN starts and out_clk=1, tick=1 at cycle k+1 (latency 1).
  - RUN: cnt advances every cycle. The cycle with cnt=N-1 is the period boundary (last low cycle).
  - STOP (RUN with en=0): the current period finishes through its last low cycle, then IDLE; out_clk stays 0 afterwards. If en returns to 1 before the boundary, the next period follows with no gap and the block stays in RUN.
- Config handshake:
  - Transfer happens on any edge where cfg_valid && cfg_ready.
  - cfg_ready = !pending.
  - Illegal ratio (cfg_div<2): rejected. cfg_err=1 for exactly one cycle after the transfer; div_active and pending are unchanged.
  - Legal ratio in IDLE: div_active updates on the next cycle; pending stays 0.
  - Legal ratio in RUN: stored in shadow, pending=1, cfg_ready=0.
  - At the period boundary, div_active <= shadow and the next period uses the new N. pending clears and cfg_ready returns to 1 on the cycle after the boundary.
- Simultaneous events:
  - Transfer on the boundary cycle itself: the new ratio applies to the following period only (held one period). It never truncates the period starting now.
  - en=0 and pending at the same boundary: shadow is applied, then IDLE.
  - Illegal transfer while pending=0 in RUN: only cfg_err; the period is undisturbed.
- Invariants: no high or low phase on out_clk is ever shorter than the ratio in effect dictates, and tick count equals the number of completed-or-started periods.

Test Plan:
1. Reset, en=1 at cycle 0, DEFAULT_DIV=4 -> out_clk 1,1,0,0 repeating from cycle 1; tick at cycles 1, 5, 9; div_active=4.
2. In IDLE, cfg_div=5 accepted, then en=1 -> div_active=5 next cycle; out_clk 1,1,1,0,0 repeating; tick every 5 cycles.
3. Running N=4, cfg_div=6 accepted in first high cycle -> cfg_ready=0, pending=1; current period finishes 2H/2L; next period 3H/3L with div_active=6; pending=0 and cfg_ready=1 the cycle after the boundary.
4. cfg_div=1 (and separately 0) accepted in RUN -> cfg_err pulses 1 cycle; div_active stays 4; out_clk pattern unchanged; cfg_ready stays 1.
5. Running N=6, en drops in the 2nd high cycle -> 1 more high then 3 low cycles, then IDLE with out_clk=0. Re-raising en before the boundary -> seamless next period, no gap.
6. rst_n=0 while pending=1 with shadow=7 -> next cycle all reset values (div_active=4, pending=0, out_clk=0); after en=1, the period is 2H/2L, not 7.
